// File: rtl/spi_sched_pkg.sv
// Shared definitions for the SPI result scheduler.
// Contents: scheduler state enum, host command opcode, reserved tag,
// default idle word and a pointer-width helper.
package spi_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } sched_state_t;

  localparam int unsigned SPI_WORD_W = 16;

  // Host opcode in cmd_word[15:12] that loads the requester enable mask
  localparam logic [3:0] CMD_SET_MASK = 4'hE;

  // Tag value never produced by a requester; marks the idle word
  localparam logic [3:0] TAG_RESERVED = 4'hF;

  localparam logic [SPI_WORD_W-1:0] IDLE_WORD_DFLT = {TAG_RESERVED, 12'h000};

  // Index width for a vector of n entries (at least one bit)
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   eligible  - request vector already qualified by the enable mask
//   rr_ptr    - index where the priority search starts
//   grant     - one-hot winner (zero when nothing is eligible)
//   grant_idx - binary index of the winner
//   any_grant - high when some requester won
module rr_arbiter
  import spi_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_grant
);

  int unsigned       idx;
  logic [PTR_W-1:0]  sel;

  // Walk the ring starting at rr_ptr; the first eligible index wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_REQ;
      sel = PTR_W'(idx);
      if (!any_grant && eligible[sel]) begin
        any_grant  = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/spi_result_scheduler.sv
// Round-robin scheduler sharing the 16-bit SPI result word among several
// result producers. A granted payload is tagged with its requester index and
// held in spi_word until the SPI slave pulses spi_done.
// Optional feature macro: SPI_SCHED_TIMEOUT_EN (drops a held word after
// TIMEOUT_CYC cycles without spi_done and counts drops in drop_cnt).
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   req_valid     - per-requester word available
//   req_data      - payloads, requester i at [i*PAY_W +: PAY_W]
//   req_ready     - one-hot combinational grant
//   spi_word      - registered word presented to the SPI slave
//   spi_done      - word shifted out (single-cycle pulse)
//   cmd_valid     - host command strobe
//   cmd_word      - host command word
//   enable_mask   - current requester enable mask
//   busy          - high while a tagged word is held
//   drop_cnt      - saturating dropped-word count (timeout build only)
module spi_result_scheduler
  import spi_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned PAY_W       = 12,
  parameter logic [15:0] IDLE_WORD   = IDLE_WORD_DFLT,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*PAY_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [15:0]              spi_word,
  input  logic                     spi_done,
  input  logic                     cmd_valid,
  input  logic [15:0]              cmd_word,
  output logic [NUM_REQ-1:0]       enable_mask,
  output logic                     busy
`ifdef SPI_SCHED_TIMEOUT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int unsigned PTR_W = ptr_width(NUM_REQ);
  localparam int unsigned TAG_W = SPI_WORD_W - PAY_W;

  sched_state_t       state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               any_grant;
  logic               grant_window;
  logic               load;
  logic               cmd_set_mask;
  logic               timeout_hit;
  logic [PAY_W-1:0]   sel_payload;
  logic               unused_cmd_bits;

  assign unused_cmd_bits = ^cmd_word[11:0];

  assign eligible     = req_valid & enable_mask;
  assign grant_window = (state == ST_IDLE) || spi_done;
  assign load         = grant_window && any_grant;
  assign cmd_set_mask = cmd_valid && (cmd_word[15:12] == CMD_SET_MASK);

  // No grant may escape while reset is held, even though the state reads IDLE
  assign req_ready = (reset_n && grant_window) ? grant : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Payload of the winning requester (one-hot mux)
  always_comb begin
    sel_payload = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_payload = req_data[i*PAY_W +: PAY_W];
    end
  end

  assign rr_ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = ptr_width(TIMEOUT_CYC);

  logic [CNT_W-1:0] hold_cnt;

  assign timeout_hit = (state == ST_HOLD) && !spi_done && (hold_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Hold-time counter and saturating drop counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (load) begin
        hold_cnt <= '0;
      end else if ((state == ST_HOLD) && !timeout_hit) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end else begin
        hold_cnt <= '0;
      end
      if (timeout_hit && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;

  assign timeout_hit = 1'b0;
`endif

  // State machine, held word, round-robin pointer and enable mask
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      spi_word    <= IDLE_WORD;
      rr_ptr      <= '0;
      enable_mask <= '1;
      busy        <= 1'b0;
    end else begin
      if (cmd_set_mask) begin
        enable_mask <= cmd_word[NUM_REQ-1:0];
      end
      if (load) begin
        state    <= ST_HOLD;
        busy     <= 1'b1;
        spi_word <= {TAG_W'(grant_idx), sel_payload};
        rr_ptr   <= rr_ptr_next;
      end else if (grant_window || timeout_hit) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        spi_word <= IDLE_WORD;
      end
    end
  end

endmodule

// File: doc/spi_result_scheduler.md
# spi_result_scheduler

Round-robin scheduler that shares the single 16-bit SPI result word (`eee_imgproc` SPI readdata path) among several image-processing result producers, such as colour bounding-box and centroid channels. Each granted payload is tagged with its requester index and held stable until the SPI slave reports that the word has been shifted out. A host command word written over the same SPI link sets which requesters are enabled. The block sits between the detection logic and the SPI interface inside the imgproc subsystem.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters. Legal range 1..8.
- `PAY_W`, default 12: payload width. Tag width is 16-PAY_W (4 by default).
- `IDLE_WORD`, default 16'hF000: word presented when nothing is pending. Tag 4'hF is reserved.
- `TIMEOUT_CYC`, default 1_000_000: hold limit in cycles. Used only when the timeout macro is enabled.

Ports (clock and reset first):
- `clk` in 1: single clock. Everything is synchronous to its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester word available.
- `req_data` in NUM_REQ*PAY_W: payloads. Requester i occupies bits [i*PAY_W +: PAY_W].
- `req_ready` out NUM_REQ: one-hot grant, combinational, high for one cycle.
- `spi_word` out 16: registered word presented to the SPI slave.
- `spi_done` in 1: one-cycle pulse when the SPI slave has shifted out `spi_word`. Already synchronised to `clk`.
- `cmd_valid` in 1: one-cycle pulse, host command word available.
- `cmd_word` in 16: host command.
- `enable_mask` out NUM_REQ: current requester enable mask.
- `busy` out 1: high while in the HOLD state.
- `drop_cnt` out 8: saturating count of dropped words. Present only when the timeout macro is enabled.

## Operation
- State machine with two states:
  - IDLE: `spi_word` = IDLE_WORD.
  - HOLD: a tagged word is latched in `spi_word`.
- Grant window is open when the state is IDLE, or when the state is HOLD and `spi_done`=1 in the same cycle.
- Eligible requesters: `req_valid` & `enable_mask`.
- Priority is round-robin:
  - Search starts at `rr_ptr`. The first eligible index wins.
  - After a grant to index g, `rr_ptr` <= (g+1) mod NUM_REQ.
- On a grant:
  - `req_ready[g]`=1 in that cycle.
  - `spi_word` <= {tag = g zero-extended, `req_data[g]`}.
  - State <= HOLD.
- Behaviour in HOLD:
  - `spi_done` with no eligible requester: `spi_word` <= IDLE_WORD, state <= IDLE.
  - `spi_done` with an eligible requester: the next word loads back-to-back and the state stays HOLD.
- `spi_done` in IDLE is ignored. The host has read IDLE_WORD.
- A requester may drop `req_valid` before it is granted. Nothing is latched from it in that case.
- Host commands:
  - `cmd_valid` with `cmd_word[15:12]`==4'hE sets `enable_mask` <= `cmd_word[NUM_REQ-1:0]`. The new mask takes effect from the next cycle.
  - Any other opcode is ignored.
  - Masking a requester does not revoke a word already in HOLD.

## Timing
- Values after reset:
  - state IDLE.
  - `spi_word`=IDLE_WORD.
  - `req_ready`=0.
  - `enable_mask`=all ones.
  - `rr_ptr`=0.
  - `busy`=0.
  - `drop_cnt`=0.
- Grant latency: with `req_valid` high in cycle n in IDLE, `req_ready` is high in cycle n and `spi_word` is valid from cycle n+1.
- Maximum throughput is one word per `spi_done`. There is no idle bubble between back-to-back words.
- `spi_done` and `cmd_valid` in the same cycle are both applied. The grant in that cycle uses the old mask.
- Reset asserted mid-HOLD: the word is lost and no `req_ready` is issued. Requesters keep their data.

## Configuration
- `SPI_SCHED_TIMEOUT_EN` defined:
  - A cycle counter runs while in HOLD and clears on every load.
  - When it reaches TIMEOUT_CYC-1 without `spi_done`, the word is dropped: `drop_cnt` increments (saturating at 255), `spi_word` <= IDLE_WORD, state <= IDLE.
  - `drop_cnt` port is present.
- `SPI_SCHED_TIMEOUT_EN` undefined:
  - HOLD lasts indefinitely.
  - No counter logic and no `drop_cnt` port.

## Structure
- Shared package `spi_sched_pkg` contains:
  - the state enum (IDLE, HOLD);
  - the CMD_SET_MASK opcode (4'hE);
  - the reserved tag 4'hF;
  - the IDLE_WORD constant.
- Sub-module `rr_arbiter`: combinational, parameterised by NUM_REQ. Inputs are the eligible vector and `rr_ptr`; outputs are the one-hot grant, its index, and an any-grant flag.
- The top level holds the state machine, `spi_word`, `rr_ptr`, the mask, and the optional timeout counter.

## Test plan
- Reset, no requests: `spi_word`=16'hF000, `busy`=0, `enable_mask`=4'b1111.
- Single word: `req_valid[2]`=1 with data 12'hABC. Expect `req_ready[2]` for one cycle, then `spi_word`=16'h2ABC and `busy`=1. After `spi_done`, `spi_word`=16'hF000.
- Fairness: all four requesters continuously valid with 8 `spi_done` pulses. Expect tags in the order 0,1,2,3,0,1,2,3, loaded back-to-back with no IDLE_WORD between them.
- Mask: `cmd_word`=16'hE005 leaves only requesters 0 and 2 granted, alternating. `cmd_word`=16'h1234 leaves the mask unchanged.
- Simultaneous: `spi_done` and `cmd_valid` (16'hE000) in the same cycle with `req_valid[1]` high. Requester 1 is still granted; the next `spi_done` returns `spi_word` to 16'hF000.
- With `SPI_SCHED_TIMEOUT_EN` and TIMEOUT_CYC=16: HOLD with no `spi_done`. After 16 cycles `spi_word`=16'hF000 and `drop_cnt`=1. After 300 drops, `drop_cnt` holds at 255.
